if_fetch_unit: RTL and testbench

Instruction-fetch stage of the pipelined MIPS processor, sitting directly upstream of the combinational instruction ROM. It owns the program counter, drives the ROM address and enable, and chooses the next PC from sequential, branch/jump/jr redirect, exception and interrupt sources. It captures the ROM word into the IF/ID pipeline register with a valid bit, and supports stall and flush. It preserves the kernel/supervisor bit PC[31] and reports the exception return address (EPC) to the register file ($26).

---
 rtl/if_fetch_unit.sv | 171 +++++++++++++++++
 tb/tb_if_fetch_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage of the pipelined MIPS core. Owns the program
// counter and drives the combinational instruction ROM. It picks the next PC
// from these sources, highest priority first: illegal-instruction exception,
// external interrupt, downstream redirect (branch/jump/jr), stall, and
// sequential fetch. The fetched word is captured into the IF/ID register
// together with a valid bit. PC[31] is the kernel/supervisor bit.
//
// Configuration macro: IF_IRQ_EN
//   defined   -> the irq input can redirect fetch to IRQ_VECTOR and write epc
//   undefined -> irq is ignored; epc/epc_we are driven only by exc_req
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous, active-high reset
//   stall            hold PC and IF/ID (load-use hazard)
//   redirect_valid   control transfer resolved downstream this cycle
//   redirect_kind    00 branch, 01 jump, 10 jr, 11 treated as jump
//   redirect_target  redirect target address
//   exc_req          illegal instruction detected in ID
//   irq              level-sensitive external interrupt
//   inst_enable      ROM enable (low while reset is asserted)
//   instAddress      ROM address, equal to the PC
//   inst             ROM data for instAddress
//   ifid_inst        captured instruction (0 for a bubble)
//   ifid_pc_plus4    PC+4 of the captured instruction
//   ifid_valid       captured instruction is real
//   epc              exception/interrupt return address for $26
//   epc_we           one-cycle write strobe for epc
// ---------------------------------------------------------------------------
module if_fetch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [1:0]  redirect_kind,
  input  logic [31:0] redirect_target,
  input  logic        exc_req,
  input  logic        irq,
  output logic        inst_enable,
  output logic [31:0] instAddress,
  input  logic [31:0] inst,
  output logic [31:0] ifid_inst,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic [31:0] epc,
  output logic        epc_we
);

  localparam logic [31:0] RESET_PC   = 32'h8000_0000;
  localparam logic [31:0] EXC_VECTOR = 32'h8000_0008;
`ifdef IF_IRQ_EN
  localparam logic [31:0] IRQ_VECTOR = 32'h8000_0004;
`endif

  localparam logic [1:0] KIND_JR = 2'b10;

  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_inst_q, ifid_inst_d;
  logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] epc_q, epc_d;
  logic        epc_we_q, epc_we_d;

  logic [31:0] pc_plus4;
  logic [31:0] redirect_pc;

`ifdef IF_IRQ_EN
  logic        irq_take;

  // Interrupts are only accepted from user mode, and an exception in the
  // same cycle wins.
  assign irq_take = irq & ~pc_q[31] & ~exc_req;
`else
  logic        unused_irq;

  assign unused_irq = irq;
`endif

  assign instAddress   = pc_q;
  assign inst_enable   = ~reset;
  assign ifid_inst     = ifid_inst_q;
  assign ifid_pc_plus4 = ifid_pc_plus4_q;
  assign ifid_valid    = ifid_valid_q;
  assign epc           = epc_q;
  assign epc_we        = epc_we_q;

  // The increment never carries into the mode bit, so sequential fetch
  // wraps inside the current half of the address space.
  assign pc_plus4 = {pc_q[31], pc_q[30:0] + 31'd4};

  // Mode-bit rules for redirect targets: branch and jump stay in the current
  // mode; jr may drop from kernel to user but never climb from user to kernel.
  always_comb begin
    if (redirect_kind == KIND_JR) begin
      redirect_pc = pc_q[31] ? redirect_target : {1'b0, redirect_target[30:0]};
    end else begin
      redirect_pc = {pc_q[31], redirect_target[30:0]};
    end
  end

  // Next-PC and IF/ID selection. Every control transfer flushes IF/ID to a
  // nop bubble; a plain stall leaves everything as it is.
  always_comb begin
    pc_d            = pc_q;
    ifid_inst_d     = ifid_inst_q;
    ifid_pc_plus4_d = ifid_pc_plus4_q;
    ifid_valid_d    = ifid_valid_q;
    epc_d           = epc_q;
    epc_we_d        = 1'b0;

    if (exc_req) begin
      // The faulting instruction sits in ID; return past it.
      pc_d            = EXC_VECTOR;
      epc_d           = ifid_pc_plus4_q;
      epc_we_d        = 1'b1;
      ifid_inst_d     = 32'd0;
      ifid_pc_plus4_d = 32'd0;
      ifid_valid_d    = 1'b0;
`ifdef IF_IRQ_EN
    end else if (irq_take) begin
      // Return to whatever would have executed next: the redirect target,
      // the instruction held in ID during a stall, or the discarded fetch.
      pc_d            = IRQ_VECTOR;
      epc_we_d        = 1'b1;
      if (redirect_valid) begin
        epc_d = redirect_pc;
      end else if (stall) begin
        epc_d = ifid_pc_plus4_q - 32'd4;
      end else begin
        epc_d = pc_q;
      end
      ifid_inst_d     = 32'd0;
      ifid_pc_plus4_d = 32'd0;
      ifid_valid_d    = 1'b0;
`endif
    end else if (redirect_valid) begin
      pc_d            = redirect_pc;
      ifid_inst_d     = 32'd0;
      ifid_pc_plus4_d = 32'd0;
      ifid_valid_d    = 1'b0;
    end else if (!stall) begin
      pc_d            = pc_plus4;
      ifid_inst_d     = inst;
      ifid_pc_plus4_d = pc_plus4;
      ifid_valid_d    = 1'b1;
    end
  end

  // State registers; reset also kills a pending epc_we immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q            <= RESET_PC;
      ifid_inst_q     <= 32'd0;
      ifid_pc_plus4_q <= 32'd0;
      ifid_valid_q    <= 1'b0;
      epc_q           <= 32'd0;
      epc_we_q        <= 1'b0;
    end else begin
      pc_q            <= pc_d;
      ifid_inst_q     <= ifid_inst_d;
      ifid_pc_plus4_q <= ifid_pc_plus4_d;
      ifid_valid_q    <= ifid_valid_d;
      epc_q           <= epc_d;
      epc_we_q        <= epc_we_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
//
// Scoreboard bench for if_fetch_unit. A stimulus process drives inputs on
// the falling edge, advances a behavioural model of the fetch stage and
// queues the state the DUT must show after the next rising edge. A monitor
// process pops that entry after each rising edge and compares it.
// Honours IF_IRQ_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h8000_0000;
  localparam logic [31:0] IRQ_VECTOR = 32'h8000_0004;
  localparam logic [31:0] EXC_VECTOR = 32'h8000_0008;
  localparam logic [31:0] KBIT       = 32'h8000_0000;
  localparam logic [31:0] ADDR_MASK  = 32'h7FFF_FFFF;
`ifdef IF_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [1:0]  redirect_kind;
  logic [31:0] redirect_target;
  logic        exc_req;
  logic        irq;
  logic        inst_enable;
  logic [31:0] instAddress;
  logic [31:0] inst;
  logic [31:0] ifid_inst;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic [31:0] epc;
  logic        epc_we;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] pp4;
    logic        valid;
    logic [31:0] epc;
    logic        we;
  } exp_t;

  exp_t exp_q[$];

  int n_vec  = 0;
  int n_fail = 0;

  // Behavioural model state: what the fetch stage should hold right now.
  logic [31:0] m_pc, m_inst, m_pp4, m_epc;
  logic        m_valid, m_we;

  if_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_kind   (redirect_kind),
    .redirect_target (redirect_target),
    .exc_req         (exc_req),
    .irq             (irq),
    .inst_enable     (inst_enable),
    .instAddress     (instAddress),
    .inst            (inst),
    .ifid_inst       (ifid_inst),
    .ifid_pc_plus4   (ifid_pc_plus4),
    .ifid_valid      (ifid_valid),
    .epc             (epc),
    .epc_we          (epc_we)
  );

  always #5 clk = ~clk;

  // Synthetic ROM: a scrambled function of the address so every word differs.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  assign inst = rom_word(instAddress);

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic resetModel();
    m_pc    = RESET_PC;
    m_inst  = 32'd0;
    m_pp4   = 32'd0;
    m_valid = 1'b0;
    m_epc   = 32'd0;
    m_we    = 1'b0;
  endtask

  // One clock of the fetch stage, described by its architectural rules.
  task automatic modelStep(input logic s, input logic rv, input logic [1:0] k,
                           input logic [31:0] t, input logic e, input logic i);
    bit          kernel;
    logic [31:0] seq_pc, tgt, old_pc, old_pp4;
    kernel  = (m_pc >= KBIT);
    old_pc  = m_pc;
    old_pp4 = m_pp4;
    seq_pc  = (m_pc & KBIT) | ((m_pc + 32'd4) & ADDR_MASK);
    if (k == 2'b10) tgt = kernel ? t : (t & ADDR_MASK);
    else            tgt = (t & ADDR_MASK) | (m_pc & KBIT);
    m_we = 1'b0;
    if (e) begin
      m_pc = EXC_VECTOR; m_epc = old_pp4; m_we = 1'b1;
      m_inst = 0; m_pp4 = 0; m_valid = 0;
    end else if (IRQ_EN && i && !kernel) begin
      m_pc = IRQ_VECTOR; m_we = 1'b1;
      m_epc = rv ? tgt : (s ? old_pp4 - 32'd4 : old_pc);
      m_inst = 0; m_pp4 = 0; m_valid = 0;
    end else if (rv) begin
      m_pc = tgt; m_inst = 0; m_pp4 = 0; m_valid = 0;
    end else if (!s) begin
      m_inst = rom_word(old_pc); m_pp4 = seq_pc; m_valid = 1'b1; m_pc = seq_pc;
    end
  endtask

  task automatic applyStimulus(input logic s, input logic rv, input logic [1:0] k,
                               input logic [31:0] t, input logic e, input logic i);
    exp_t x;
    @(negedge clk);
    stall = s; redirect_valid = rv; redirect_kind = k;
    redirect_target = t; exc_req = e; irq = i;
    modelStep(s, rv, k, t, e, i);
    x.pc = m_pc; x.inst = m_inst; x.pp4 = m_pp4;
    x.valid = m_valid; x.epc = m_epc; x.we = m_we;
    exp_q.push_back(x);
  endtask

  task automatic seqCycles(input int n);
    for (int c = 0; c < n; c++) applyStimulus(1'b0, 1'b0, 2'b00, 32'd0, 1'b0, 1'b0);
  endtask

  // Monitor: after each rising edge compare the DUT with the oldest entry.
  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && exp_q.size() > 0) begin
        x = exp_q.pop_front();
        checkOutput("instAddress", instAddress, x.pc);
        checkOutput("inst_enable", {31'd0, inst_enable}, 32'd1);
        checkOutput("ifid_inst", ifid_inst, x.inst);
        checkOutput("ifid_pc_plus4", ifid_pc_plus4, x.pp4);
        checkOutput("ifid_valid", {31'd0, ifid_valid}, {31'd0, x.valid});
        checkOutput("epc", epc, x.epc);
        checkOutput("epc_we", {31'd0, epc_we}, {31'd0, x.we});
      end
    end
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_pc"}, instAddress, RESET_PC);
    checkOutput({tag, "_enable"}, {31'd0, inst_enable}, 32'd0);
    checkOutput({tag, "_ifid_inst"}, ifid_inst, 32'd0);
    checkOutput({tag, "_ifid_pp4"}, ifid_pc_plus4, 32'd0);
    checkOutput({tag, "_ifid_valid"}, {31'd0, ifid_valid}, 32'd0);
    checkOutput({tag, "_epc"}, epc, 32'd0);
    checkOutput({tag, "_epc_we"}, {31'd0, epc_we}, 32'd0);
  endtask

  initial begin : stimulus
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_kind = 2'b00;
    redirect_target = 32'd0; exc_req = 1'b0; irq = 1'b0;
    resetModel();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checkResetState("reset");
    // Release between a rising and falling edge so the model and DUT step together.
    @(posedge clk);
    #2 reset = 1'b0;

    // Boot fetch from RESET_PC.
    seqCycles(2);
    // Kernel jr into user code, then stall twice and resume.
    applyStimulus(1'b0, 1'b1, 2'b10, 32'h0040_0010, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'b00, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'b00, 32'd0, 1'b0, 1'b0);
    seqCycles(2);
    // Jump to 0040_0020, then a user branch whose target has bit 31 set.
    applyStimulus(1'b0, 1'b1, 2'b01, 32'h0040_0020, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b00, 32'h8040_0000, 1'b0, 1'b0);
    seqCycles(2);
    // User jr cannot enter kernel space.
    applyStimulus(1'b0, 1'b1, 2'b10, 32'h8000_0010, 1'b0, 1'b0);
    seqCycles(1);
    // Exception into kernel, then kernel jr back to user.
    applyStimulus(1'b0, 1'b0, 2'b00, 32'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b10, 32'h0040_0024, 1'b0, 1'b0);
    seqCycles(1);
    // Interrupt together with a jump; then irq held in kernel mode.
    applyStimulus(1'b0, 1'b1, 2'b01, 32'h0040_0030, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b01, 32'h0040_0100, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) applyStimulus(1'b0, 1'b0, 2'b00, 32'd0, 1'b0, 1'b1);
    // Exception beats a concurrent irq and stall.
    applyStimulus(1'b0, 1'b1, 2'b10, 32'h0040_0040, 1'b0, 1'b0);
    seqCycles(1);
    applyStimulus(1'b1, 1'b0, 2'b00, 32'd0, 1'b1, 1'b1);
    // Interrupt during a stall re-executes the instruction held in ID.
    applyStimulus(1'b0, 1'b1, 2'b10, 32'h0040_0200, 1'b0, 1'b0);
    seqCycles(2);
    applyStimulus(1'b1, 1'b0, 2'b00, 32'd0, 1'b0, 1'b1);
    seqCycles(1);
    // Increment wrap in both halves of the address space.
    applyStimulus(1'b0, 1'b1, 2'b10, 32'h7FFF_FFFC, 1'b0, 1'b0);
    seqCycles(2);
    applyStimulus(1'b0, 1'b0, 2'b00, 32'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b10, 32'hFFFF_FFFC, 1'b0, 1'b0);
    seqCycles(2);

    // Randomized traffic.
    for (int c = 0; c < 500; c++) begin
      applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                    2'($urandom_range(0, 3)), ($urandom & 32'hFFFF_FFFC),
                    ($urandom_range(0, 19) == 0), ($urandom_range(0, 4) == 0));
    end

    // Reset in the middle of operation, right as epc_we is high.
    applyStimulus(1'b0, 1'b0, 2'b00, 32'd0, 1'b1, 1'b0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkResetState("midreset");
    stall = 1'b0; redirect_valid = 1'b0; exc_req = 1'b0; irq = 1'b0;
    resetModel();
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    seqCycles(3);

    repeat (2) @(negedge clk);
    checkOutput("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
